// File: rtl/out_buff_writer_if.sv
// Single-port output-buffer SRAM bus and its write-request encoding (W_req is active-low).
// Synchronous SRAM: writes commit on the cs/W_req edge, R_data is valid the cycle after a cs/oe read.
package out_buff_pkg;
    localparam logic WRITE_ENB = 1'b0;
    localparam logic WRITE_DIS = 1'b1;
endpackage

interface sp_ram_intf #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
);
    logic              cs;
    logic              oe;
    logic [ADDR_W-1:0] addr;
    logic              W_req;
    logic [DATA_W-1:0] W_data;
    logic [DATA_W-1:0] R_data;

    modport master (output cs, oe, addr, W_req, W_data, input R_data);
    modport slave  (input cs, oe, addr, W_req, W_data, output R_data);
endinterface

// File: rtl/out_buff_writer.sv
// Output-buffer write master: result stream to SRAM writes; OUT_WRITER_ACC_EN adds read-accumulate-write.
// Zero-latency writes at 1 word/cycle (1 per 2 cycles when accumulating); res_ready_o never depends on res_valid_i.
module out_buff_writer #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic              acc_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] len_i,
    input  logic              res_valid_i,
    input  logic [DATA_W-1:0] res_data_i,
    output logic              res_ready_o,
    output logic              busy_o,
    output logic              finish_o,
    sp_ram_intf.master        bus
);
    import out_buff_pkg::*;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        DONE   = 3'd2
`ifdef OUT_WRITER_ACC_EN
        ,
        RD     = 3'd3,
        ACC_WR = 3'd4
`endif
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] cnt;
    logic              cnt_inc;
    logic              last_word;
    logic [ADDR_W-1:0] word_addr;

    logic              cs_c;
    logic              oe_c;
    logic [ADDR_W-1:0] addr_c;
    logic              w_req_c;
    logic [DATA_W-1:0] w_data_c;

`ifdef OUT_WRITER_ACC_EN
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] acc_sum;
`else
    logic              unused_acc;
    logic              unused_rdata;
    assign unused_acc   = acc_i;
    assign unused_rdata = ^bus.R_data;
`endif

    assign last_word = (cnt == len_q - 1'b1);
    assign word_addr = base_q + cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            base_q <= '0;
            len_q  <= '0;
            cnt    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start_i) begin
                base_q <= base_addr_i;
                len_q  <= len_i;
                cnt    <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef OUT_WRITER_ACC_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold <= '0;
        end else if (state == RD && res_valid_i) begin
            hold <= res_data_i;
        end
    end

    // Modular add: overflow wraps, no saturation.
    assign acc_sum = bus.R_data + hold;
`endif

    always_comb begin
        state_nx    = state;
        res_ready_o = 1'b0;
        busy_o      = (state != IDLE);
        finish_o    = 1'b0;
        cnt_inc     = 1'b0;
        cs_c        = 1'b0;
        oe_c        = 1'b0;
        addr_c      = '0;
        w_req_c     = WRITE_DIS;
        w_data_c    = '0;

        case (state)
            IDLE: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        state_nx = DONE;
                    end else begin
`ifdef OUT_WRITER_ACC_EN
                        state_nx = acc_i ? RD : WRITE;
`else
                        state_nx = WRITE;
`endif
                    end
                end
            end
            WRITE: begin
                res_ready_o = 1'b1;
                if (res_valid_i) begin
                    cs_c     = 1'b1;
                    addr_c   = word_addr;
                    w_req_c  = WRITE_ENB;
                    w_data_c = res_data_i;
                    cnt_inc  = 1'b1;
                    if (last_word) begin
                        state_nx = DONE;
                    end
                end
                if (!start_i) begin
                    state_nx = IDLE;
                end
            end
`ifdef OUT_WRITER_ACC_EN
            // The read is issued every RD cycle so R_data is ready whenever the handshake lands.
            RD: begin
                res_ready_o = 1'b1;
                cs_c        = 1'b1;
                oe_c        = 1'b1;
                addr_c      = word_addr;
                if (res_valid_i) begin
                    state_nx = ACC_WR;
                end
                if (!start_i) begin
                    state_nx = IDLE;
                end
            end
            ACC_WR: begin
                cs_c     = 1'b1;
                addr_c   = word_addr;
                w_req_c  = WRITE_ENB;
                w_data_c = acc_sum;
                cnt_inc  = 1'b1;
                state_nx = last_word ? DONE : RD;
                if (!start_i) begin
                    state_nx = IDLE;
                end
            end
`endif
            DONE: begin
                finish_o = 1'b1;
                if (!start_i) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.cs     = cs_c;
    assign bus.oe     = oe_c;
    assign bus.addr   = addr_c;
    assign bus.W_req  = w_req_c;
    assign bus.W_data = w_data_c;

endmodule

// File: tb/tb_out_buff_writer.sv
// Directed bench for out_buff_writer with a synchronous SRAM model and a write log.
// The accumulate scenario runs when OUT_WRITER_ACC_EN is defined; otherwise acc_i must be ignored.
module tb_out_buff_writer;
    import out_buff_pkg::*;

    logic        clk;
    logic        rstn;
    logic        start_i;
    logic        acc_i;
    logic [17:0] base_addr_i;
    logic [17:0] len_i;
    logic        res_valid_i;
    logic [31:0] res_data_i;
    logic        res_ready_o;
    logic        busy_o;
    logic        finish_o;

    sp_ram_intf #(.ADDR_W(18), .DATA_W(32)) bus_if ();

    out_buff_writer #(.ADDR_W(18), .DATA_W(32)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start_i     (start_i),
        .acc_i       (acc_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
        .res_valid_i (res_valid_i),
        .res_data_i  (res_data_i),
        .res_ready_o (res_ready_o),
        .busy_o      (busy_o),
        .finish_o    (finish_o),
        .bus         (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:262143];
    logic [17:0] wlog_a [$];
    logic [31:0] wlog_d [$];
    int          n_rd;
    logic        pre_en;
    logic [17:0] pre_a;
    logic [31:0] pre_d;

    initial n_rd = 0;

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_a] <= pre_d;
        end
        if (bus_if.cs && bus_if.W_req == WRITE_ENB) begin
            mem[bus_if.addr] <= bus_if.W_data;
            wlog_a.push_back(bus_if.addr);
            wlog_d.push_back(bus_if.W_data);
        end
        if (bus_if.cs && bus_if.oe) begin
            bus_if.R_data <= mem[bus_if.addr];
            n_rd <= n_rd + 1;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"},  res_ready_o,   1'b0);
        check({tag, "_busy"},   busy_o,        1'b0);
        check({tag, "_finish"}, finish_o,      1'b0);
        check({tag, "_cs"},     bus_if.cs,     1'b0);
        check({tag, "_oe"},     bus_if.oe,     1'b0);
        check({tag, "_addr"},   bus_if.addr,   18'h0);
        check({tag, "_wdata"},  bus_if.W_data, 32'h0);
        check({tag, "_wreq"},   bus_if.W_req,  WRITE_DIS);
    endtask

    int s;
    int r0;
    int k;

    initial begin
        rstn = 1'b0; start_i = 1'b0; acc_i = 1'b0; base_addr_i = '0; len_i = '0;
        res_valid_i = 1'b0; res_data_i = '0; pre_en = 1'b0; pre_a = '0; pre_d = '0;
        bus_if.R_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rstn = 1'b1;
        tick();

        // Plain write: base 0x100, four words, valid held high.
        s = wlog_a.size();
        base_addr_i = 18'h100; len_i = 18'd4; start_i = 1'b1; res_valid_i = 1'b1;
        #1;
        check("t1_idle_ready", res_ready_o, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            res_data_i = 32'(i + 1);
            #1;
            check("t1_ready", res_ready_o, 1'b1);
            check("t1_cs", bus_if.cs, 1'b1);
            check("t1_wreq", bus_if.W_req, WRITE_ENB);
            check("t1_addr", bus_if.addr, 18'h100 + 18'(i));
            check("t1_wdata", bus_if.W_data, 32'(i + 1));
            tick();
        end
        check("t1_finish_hi", finish_o, 1'b1);
        check("t1_done_cs", bus_if.cs, 1'b0);
        check("t1_done_busy", busy_o, 1'b1);
        start_i = 1'b0; res_valid_i = 1'b0;
        tick();
        check("t1_finish_lo", finish_o, 1'b0);
        check("t1_busy_lo", busy_o, 1'b0);
        check("t1_nwrites", wlog_a.size() - s, 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_log_addr", wlog_a[s + i], 18'h100 + 18'(i));
            check("t1_log_data", wlog_d[s + i], 32'(i + 1));
        end

        // Backpressure: valid toggles 1,0,1,0,1 with len 3.
        s = wlog_a.size();
        base_addr_i = 18'h200; len_i = 18'd3; start_i = 1'b1; res_valid_i = 1'b0;
        tick();
        k = 0;
        while (!finish_o && k < 20) begin
            res_valid_i = (k % 2 == 0);
            res_data_i  = 32'hA0 + 32'(k);
            #1;
            if (!res_valid_i) check("t2_gap_cs", bus_if.cs, 1'b0);
            tick();
            k++;
        end
        check("t2_finish", finish_o, 1'b1);
        check("t2_nwrites", wlog_a.size() - s, 3);
        check("t2_mem0", mem[18'h200], 32'hA0);
        check("t2_mem1", mem[18'h201], 32'hA2);
        check("t2_mem2", mem[18'h202], 32'hA4);
        start_i = 1'b0; res_valid_i = 1'b0;
        tick();

        // Zero-length layer.
        s = wlog_a.size(); r0 = n_rd;
        base_addr_i = 18'h300; len_i = 18'd0; start_i = 1'b1; res_valid_i = 1'b1;
        #1;
        check("t3_finish_pre", finish_o, 1'b0);
        tick();
        check("t3_finish", finish_o, 1'b1);
        check("t3_cs", bus_if.cs, 1'b0);
        check("t3_ready", res_ready_o, 1'b0);
        start_i = 1'b0; res_valid_i = 1'b0;
        tick();
        check("t3_finish_lo", finish_o, 1'b0);
        check("t3_nwrites", wlog_a.size() - s, 0);
        check("t3_nreads", n_rd - r0, 0);

        // Address wrap at the top of the 18-bit space.
        s = wlog_a.size();
        base_addr_i = 18'h3FFFF; len_i = 18'd2; start_i = 1'b1; res_valid_i = 1'b1;
        res_data_i = 32'h55;
        tick();
        tick();
        res_data_i = 32'h66;
        tick();
        check("t4_finish", finish_o, 1'b1);
        check("t4_nwrites", wlog_a.size() - s, 2);
        check("t4_addr0", wlog_a[s], 18'h3FFFF);
        check("t4_addr1", wlog_a[s + 1], 18'h00000);
        check("t4_mem0", mem[18'h00000], 32'h66);
        start_i = 1'b0; res_valid_i = 1'b0;
        tick();

`ifdef OUT_WRITER_ACC_EN
        // Read-accumulate-write: 10+1=11, 20+0xFFFFFFFF=19.
        pre_en = 1'b1; pre_a = 18'd5; pre_d = 32'd10;
        tick();
        pre_a = 18'd6; pre_d = 32'd20;
        tick();
        pre_en = 1'b0;
        base_addr_i = 18'd5; len_i = 18'd2; acc_i = 1'b1; start_i = 1'b1;
        res_valid_i = 1'b1; res_data_i = 32'd1;
        tick();
        check("t5_rd_oe", bus_if.oe, 1'b1);
        check("t5_rd_cs", bus_if.cs, 1'b1);
        check("t5_rd_wreq", bus_if.W_req, WRITE_DIS);
        check("t5_rd_addr", bus_if.addr, 18'd5);
        check("t5_rd_ready", res_ready_o, 1'b1);
        tick();
        check("t5_wr_ready", res_ready_o, 1'b0);
        check("t5_wr_oe", bus_if.oe, 1'b0);
        check("t5_wr_wreq", bus_if.W_req, WRITE_ENB);
        check("t5_wr_data", bus_if.W_data, 32'd11);
        res_data_i = 32'hFFFF_FFFF;
        tick();
        check("t5_rd2_addr", bus_if.addr, 18'd6);
        check("t5_rd2_oe", bus_if.oe, 1'b1);
        tick();
        check("t5_wr2_ready", res_ready_o, 1'b0);
        check("t5_wr2_data", bus_if.W_data, 32'd19);
        tick();
        check("t5_finish", finish_o, 1'b1);
        check("t5_mem5", mem[18'd5], 32'd11);
        check("t5_mem6", mem[18'd6], 32'd19);
        start_i = 1'b0; acc_i = 1'b0; res_valid_i = 1'b0;
        tick();
`else
        // Without the accumulate build, acc_i=1 still produces a plain write.
        s = wlog_a.size(); r0 = n_rd;
        base_addr_i = 18'h300; len_i = 18'd1; acc_i = 1'b1; start_i = 1'b1;
        res_valid_i = 1'b1; res_data_i = 32'h7;
        tick();
        check("t5_oe", bus_if.oe, 1'b0);
        check("t5_ready", res_ready_o, 1'b1);
        check("t5_wreq", bus_if.W_req, WRITE_ENB);
        tick();
        check("t5_finish", finish_o, 1'b1);
        check("t5_nreads", n_rd - r0, 0);
        check("t5_mem", mem[18'h300], 32'h7);
        start_i = 1'b0; acc_i = 1'b0; res_valid_i = 1'b0;
        tick();
`endif

        // Abort after two of eight words.
        s = wlog_a.size();
        base_addr_i = 18'h400; len_i = 18'd8; start_i = 1'b1; res_valid_i = 1'b1;
        res_data_i = 32'h10;
        tick();
        tick();
        res_data_i = 32'h11;
        tick();
        start_i = 1'b0; res_valid_i = 1'b0;
        tick();
        check("t6_busy", busy_o, 1'b0);
        check("t6_finish", finish_o, 1'b0);
        tick();
        check("t6_finish_later", finish_o, 1'b0);
        check("t6_nwrites", wlog_a.size() - s, 2);

        // Asynchronous reset mid-layer.
        base_addr_i = 18'h500; len_i = 18'd8; start_i = 1'b1; res_valid_i = 1'b1;
        res_data_i = 32'h20;
        tick();
        tick();
        check("t7_pre_cs", bus_if.cs, 1'b1);
        rstn = 1'b0;
        #1;
        check_idle_outputs("t7_rst");
        start_i = 1'b0; res_valid_i = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        check("t7_busy_after", busy_o, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/out_buff_writer.md
# out_buff_writer

EPU-side write master for the 384 KB output buffer. Accepts the convolution engine's result stream and turns it into single-port SRAM write (and, optionally, read-accumulate-write) cycles on the `sp_ram_intf` bus. It drives the buffer's EPU-side port during the output wrapper's `EPU_RW` phase. It signals layer completion with the `start`/`finish` handshake that the output wrapper uses to return to `IDLE`.

## Interface
- `ADDR_W`, default 18: SRAM word-address width, matching the buffer's `addr[19:2]` mapping.
- `DATA_W`, default 32: result and SRAM word width.
- `clk` in 1: the only clock.
- `rstn` in 1: reset, asynchronous and active-low.
- `start_i` in 1: layer request, a level held high until `finish_o` is seen.
- `acc_i` in 1: accumulate mode; honoured only with `OUT_WRITER_ACC_EN`.
- `base_addr_i` in ADDR_W: first word address; sampled when leaving `IDLE`.
- `len_i` in ADDR_W: number of result words; sampled when leaving `IDLE`.
- `res_valid_i` in 1: result word valid.
- `res_data_i` in DATA_W: result word.
- `res_ready_o` out 1: writer can accept a word this cycle.
- `busy_o` out 1: high in every state except `IDLE`.
- `finish_o` out 1: layer done; high in `DONE`.
- `bus` modport `sp_ram_intf.master`:
  - drives `cs`, `oe`, `addr`, `W_req`, `W_data`;
  - samples `R_data`.

## Operation
- States: `IDLE`, `WRITE`, `RD` (ACC build only), `ACC_WR` (ACC build only), `DONE`.
- `IDLE`:
  - Bus idle: `cs=0`, `oe=0`, `addr=0`, `W_req=WRITE_DIS`, `W_data=0`.
  - On `start_i=1`, latch `base_addr_i`, `len_i` and `acc_i`, and clear word counter `cnt`.
  - If `len_i==0`, go to `DONE`. Else go to `RD` if accumulate is active, otherwise `WRITE`.
- `WRITE`:
  - `res_ready_o=1`.
  - On `res_valid_i`, drive `cs=1`, `oe=0`, `addr=base+cnt`, `W_req=WRITE_ENB`, `W_data=res_data_i` in the same cycle, then increment `cnt`.
  - After the handshake where `cnt==len-1`, go to `DONE`.
  - With no valid word, the bus stays idle.
- `RD`:
  - `res_ready_o=1`.
  - On handshake, capture `res_data_i` into `hold`.
  - Drive `cs=1`, `oe=1`, `addr=base+cnt`, `W_req=WRITE_DIS`, then go to `ACC_WR`.
- `ACC_WR`:
  - `res_ready_o=0`.
  - Drive `cs=1`, `oe=0`, `addr=base+cnt`, `W_req=WRITE_ENB`, `W_data=R_data+hold`.
  - Increment `cnt`. Return to `RD`, or go to `DONE` on the last word.
- `DONE`: `finish_o=1`, bus idle. Go to `IDLE` when `start_i=0`.
- Arithmetic:
  - Address is `(base+cnt)` truncated to ADDR_W and wraps modulo 2^ADDR_W.
  - Addresses of 98304 and above are not checked.
  - The accumulate sum is a modular DATA_W two's-complement add; no saturation.
- Abort: `start_i` falling in any state other than `IDLE` or `DONE` returns to `IDLE` on the next edge. No `finish_o` is raised, and words already written stay in the SRAM.
- Reset (`rstn=0`, at any time):
  - `IDLE`, `cnt=0`, `hold=0`.
  - All outputs 0: `res_ready_o`, `busy_o`, `finish_o`, `cs`, `oe`, `addr`, `W_data`.
  - `W_req=WRITE_DIS`.

## Timing
- `res_ready_o` and all bus outputs decode from state and registers only. `W_data` in `WRITE` is the sole pass-through from `res_data_i`. There is no path from `res_valid_i` to `res_ready_o`.
- Non-ACC throughput: 1 word per cycle. Write latency is 0: the SRAM captures the word at the handshake edge.
- ACC throughput: 1 word per 2 cycles. `R_data` is valid the cycle after the `RD` read (synchronous SRAM).
- `finish_o` rises on the cycle after the last write edge, or on the cycle after `start_i` is sampled when `len=0`. It falls on the cycle after `start_i=0` is sampled.
- `start_i` re-asserted in the same cycle the writer returns to `IDLE` is seen one cycle later.

## Configuration
- `OUT_WRITER_ACC_EN` defined:
  - `RD` and `ACC_WR` states, the `hold` register and the adder are compiled in.
  - `acc_i=1` selects read-accumulate-write.
- `OUT_WRITER_ACC_EN` undefined:
  - Those states and the adder are absent; `acc_i` is ignored.
  - Every layer uses `WRITE`, and `oe` is never asserted.

## Test plan
- Plain write, base=0x100, len=4, words 1..4 with valid held high:
  - Writes land at addresses 0x100..0x103 on 4 consecutive cycles.
  - `finish_o` rises in cycle 5 and falls after `start_i` drops.
- Backpressure, valid toggling 1,0,1,0…, len=3:
  - Bus is idle on the gap cycles; exactly 3 writes.
  - Memory holds the words in order.
- `len=0`: `finish_o` rises one cycle after `start_i`; zero bus activity.
- ACC build, memory preloaded with 10,20 at base=5, results 1 and 0xFFFFFFFF, `acc_i=1`:
  - Memory ends at 11 and 19.
  - Read/write alternate; `res_ready_o` is low on every `ACC_WR` cycle.
- Wrap, base=0x3FFFF, len=2: writes go to 0x3FFFF, then 0x00000.
- Abort and reset:
  - `start_i` dropped after 2 of 8 words: back to `IDLE`, no `finish_o`.
  - `rstn` pulsed mid-layer: all outputs 0 immediately, `W_req=WRITE_DIS`.
